// File: rtl/rob_commit_buffer.sv
// Reorder buffer: in-order allocate at tail, out-of-order CDB fill, in-order retire at head.
// Optional macro ROB_CDB_BYPASS_EN lets a CDB write to the head entry commit in the same cycle.
module rob_commit_buffer #(
    parameter int DEPTH = 8,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dispatch_valid,
    output logic             dispatch_ready,
    input  logic [6:0]       dispatch_op,
    input  logic [4:0]       dispatch_rd,
    output logic [IDX_W-1:0] dispatch_rob_idx,
    input  logic             cdb_valid,
    input  logic [IDX_W-1:0] cdb_rob_idx,
    input  logic [31:0]      cdb_value,
    output logic             commit_valid,
    input  logic             commit_ready,
    output logic [6:0]       commit_op,
    output logic [4:0]       commit_rd,
    output logic [31:0]      commit_value,
    output logic [IDX_W-1:0] commit_rob_idx,
    input  logic             flush,
    output logic             empty,
    output logic             full
);

    localparam int PTR_W = IDX_W + 1;

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [IDX_W-1:0] head_idx, tail_idx;
    logic [DEPTH-1:0] valid_q, valid_d, ready_q, ready_d;
    logic [6:0]       op_q    [DEPTH];
    logic [4:0]       rd_q    [DEPTH];
    logic [31:0]      value_q [DEPTH];

    logic dispatch_fire, commit_fire, cdb_hit, head_ready, bypass_hit;

    assign head_idx = head_q[IDX_W-1:0];
    assign tail_idx = tail_q[IDX_W-1:0];

    assign empty = (head_q == tail_q);
    assign full  = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);

    assign dispatch_ready   = !full;
    assign dispatch_rob_idx = tail_idx;
    assign dispatch_fire    = dispatch_valid && !full && !flush;

    // The slot being allocated is invalid before the edge, so a CDB aimed at it never hits.
    assign cdb_hit = cdb_valid && valid_q[cdb_rob_idx] && !ready_q[cdb_rob_idx];

    assign head_ready  = valid_q[head_idx] && ready_q[head_idx];
    assign commit_fire = commit_valid && commit_ready;

`ifdef ROB_CDB_BYPASS_EN
    assign bypass_hit = cdb_hit && (cdb_rob_idx == head_idx);
`else
    assign bypass_hit = 1'b0;
`endif

    always_comb begin
        commit_valid   = (head_ready || bypass_hit) && !flush;
        commit_op      = '0;
        commit_rd      = '0;
        commit_value   = '0;
        commit_rob_idx = '0;
        if (commit_valid) begin
            commit_op      = op_q[head_idx];
            commit_rd      = rd_q[head_idx];
            commit_value   = head_ready ? value_q[head_idx] : cdb_value;
            commit_rob_idx = head_idx;
        end
    end

    assign head_d = flush ? '0 : head_q + PTR_W'(commit_fire);
    assign tail_d = flush ? '0 : tail_q + PTR_W'(dispatch_fire);

    // Retire dominates a same-cycle fill so a bypassed commit leaves the slot clean.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic alloc, retire, fill;
        assign alloc  = dispatch_fire && (tail_idx == IDX_W'(gi));
        assign retire = commit_fire && (head_idx == IDX_W'(gi));
        assign fill   = cdb_hit && (cdb_rob_idx == IDX_W'(gi));
        assign valid_d[gi] = !flush && (alloc || (valid_q[gi] && !retire));
        assign ready_d[gi] = !flush && !alloc && !retire && (ready_q[gi] || fill);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            ready_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            ready_q <= ready_d;
        end
    end

    // Payload needs no reset: it is only observed through valid/ready-gated outputs.
    always_ff @(posedge clk) begin
        if (dispatch_fire) begin
            op_q[tail_idx] <= dispatch_op;
            rd_q[tail_idx] <= dispatch_rd;
        end
        if (cdb_hit) begin
            value_q[cdb_rob_idx] <= cdb_value;
        end
    end

endmodule

// File: tb/tb_rob_commit_buffer.sv
// Randomized bench for rob_commit_buffer against a program-order queue model.
// Honors ROB_CDB_BYPASS_EN the same way the design does.
module tb_rob_commit_buffer;

    localparam int DEPTH = 8;
    localparam int IDX_W = $clog2(DEPTH);

    logic             clk;
    logic             rst_n;
    logic             dispatch_valid;
    logic             dispatch_ready;
    logic [6:0]       dispatch_op;
    logic [4:0]       dispatch_rd;
    logic [IDX_W-1:0] dispatch_rob_idx;
    logic             cdb_valid;
    logic [IDX_W-1:0] cdb_rob_idx;
    logic [31:0]      cdb_value;
    logic             commit_valid;
    logic             commit_ready;
    logic [6:0]       commit_op;
    logic [4:0]       commit_rd;
    logic [31:0]      commit_value;
    logic [IDX_W-1:0] commit_rob_idx;
    logic             flush;
    logic             empty;
    logic             full;

    rob_commit_buffer #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .dispatch_valid   (dispatch_valid),
        .dispatch_ready   (dispatch_ready),
        .dispatch_op      (dispatch_op),
        .dispatch_rd      (dispatch_rd),
        .dispatch_rob_idx (dispatch_rob_idx),
        .cdb_valid        (cdb_valid),
        .cdb_rob_idx      (cdb_rob_idx),
        .cdb_value        (cdb_value),
        .commit_valid     (commit_valid),
        .commit_ready     (commit_ready),
        .commit_op        (commit_op),
        .commit_rd        (commit_rd),
        .commit_value     (commit_value),
        .commit_rob_idx   (commit_rob_idx),
        .flush            (flush),
        .empty            (empty),
        .full             (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [31:0] val;
        bit          rdy;
    } ent_t;

    ent_t m_q[$];
    int   m_head;
    int   check_cnt;
    int   pass_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        if (obs === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic int m_tail();
        return (m_head + m_q.size()) % DEPTH;
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, then advance the model.
    task automatic step(input bit rst, input bit dv, input logic [6:0] op, input logic [4:0] rd,
                        input bit cv, input int cidx, input logic [31:0] cval,
                        input bit cr, input bit fl);
        bit          e_full, e_cv;
        logic [6:0]  e_op;
        logic [4:0]  e_rd;
        logic [31:0] e_val;
        int          e_idx;
        @(negedge clk);
        rst_n          = !rst;
        dispatch_valid = dv;
        dispatch_op    = op;
        dispatch_rd    = rd;
        cdb_valid      = cv;
        cdb_rob_idx    = IDX_W'(cidx);
        cdb_value      = cval;
        commit_ready   = cr;
        flush          = fl;
        #1;
        e_full = (m_q.size() == DEPTH);
        e_cv = 0; e_op = '0; e_rd = '0; e_val = '0; e_idx = 0;
        if (!fl && m_q.size() > 0) begin
            if (m_q[0].rdy) begin
                e_cv = 1; e_val = m_q[0].val;
            end
`ifdef ROB_CDB_BYPASS_EN
            else if (cv && cidx == m_q[0].idx) begin
                e_cv = 1; e_val = cval;
            end
`endif
            if (e_cv) begin
                e_op = m_q[0].op; e_rd = m_q[0].rd; e_idx = m_q[0].idx;
            end
        end
        if (!rst) begin
            check("dispatch_ready", 32'(dispatch_ready), 32'(!e_full));
            check("dispatch_rob_idx", 32'(dispatch_rob_idx), 32'(m_tail()));
            check("empty", 32'(empty), 32'(m_q.size() == 0));
            check("full", 32'(full), 32'(e_full));
            check("commit_valid", 32'(commit_valid), 32'(e_cv));
            check("commit_op", 32'(commit_op), 32'(e_op));
            check("commit_rd", 32'(commit_rd), 32'(e_rd));
            check("commit_value", commit_value, e_val);
            check("commit_rob_idx", 32'(commit_rob_idx), 32'(e_idx));
            if (e_cv && cr)
                $display("retire idx=%0d op=%h rd=%0d value=%h", e_idx, e_op, e_rd, e_val);
        end
        @(posedge clk);
        if (rst || fl) begin
            m_q.delete();
            m_head = 0;
        end else begin
            if (cv) begin
                foreach (m_q[i]) begin
                    if (m_q[i].idx == cidx && !m_q[i].rdy) begin
                        m_q[i].rdy = 1;
                        m_q[i].val = cval;
                    end
                end
            end
            if (e_cv && cr) begin
                void'(m_q.pop_front());
                m_head = (m_head + 1) % DEPTH;
            end
            if (dv && !e_full) begin
                ent_t e;
                e.idx = m_tail(); e.op = op; e.rd = rd; e.val = '0; e.rdy = 0;
                m_q.push_back(e);
            end
        end
    endtask

    task automatic idle(input bit cr);
        step(0, 0, '0, '0, 0, 0, '0, cr, 0);
    endtask

    initial begin
        int prev;
        check_cnt = 0; pass_cnt = 0; m_head = 0;
        rst_n = 0; dispatch_valid = 0; dispatch_op = '0; dispatch_rd = '0;
        cdb_valid = 0; cdb_rob_idx = '0; cdb_value = '0; commit_ready = 0; flush = 0;

        // Reset, then idle outputs
        step(1, 0, '0, '0, 0, 0, '0, 0, 0);
        @(negedge clk); #1;
        check("rst_dispatch_ready", 32'(dispatch_ready), 32'd1);
        check("rst_commit_valid", 32'(commit_valid), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_dispatch_rob_idx", 32'(dispatch_rob_idx), 32'd0);
        idle(0);

        // Single dispatch / CDB / commit
        step(0, 1, 7'h33, 5'd5, 0, 0, '0, 1, 0);
        step(0, 0, '0, '0, 1, 0, 32'hDEADBEEF, 1, 0);
        idle(1);
        idle(1);

        // Fill to full, ninth dispatch ignored, then flush
        for (int i = 0; i < DEPTH + 1; i++) step(0, 1, 7'(i), 5'(i), 0, 0, '0, 0, 0);
        idle(0);
        step(0, 0, '0, '0, 0, 0, '0, 0, 1);

        // Out-of-order completion
        step(0, 1, 7'h13, 5'd1, 0, 0, '0, 1, 0);
        step(0, 1, 7'h13, 5'd2, 0, 0, '0, 1, 0);
        step(0, 0, '0, '0, 1, 1, 32'h2, 1, 0);
        idle(1);
        step(0, 0, '0, '0, 1, 0, 32'h1, 1, 0);
        idle(1); idle(1); idle(1);

        // Wrap-around pipeline over 20 entries
        step(0, 0, '0, '0, 0, 0, '0, 0, 1);
        prev = 0;
        for (int i = 0; i < 20; i++) begin
            int cur;
            cur = m_tail();
            step(0, 1, 7'h33, 5'(i), i > 0, prev, 32'(i * 3 + 7), 1, 0);
            prev = cur;
        end
        step(0, 0, '0, '0, 1, prev, 32'h77, 1, 0);
        idle(1); idle(1); idle(1);

        // Flush with three entries (one ready) plus simultaneous dispatch and CDB
        for (int i = 0; i < 3; i++) step(0, 1, 7'h33, 5'(i + 10), 0, 0, '0, 0, 0);
        step(0, 0, '0, '0, 1, m_head, 32'h55, 0, 0);
        step(0, 1, 7'h03, 5'd9, 1, (m_head + 1) % DEPTH, 32'h66, 1, 1);
        idle(1);

        // CDB to the head with commit_ready high
        step(0, 1, 7'h37, 5'd3, 0, 0, '0, 1, 0);
        step(0, 0, '0, '0, 1, m_head, 32'hCAFEF00D, 1, 0);
        idle(1); idle(1);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit rst, dv, cv, cr, fl;
            int cidx;
            rst = ($urandom_range(199) == 0);
            fl  = ($urandom_range(49) == 0);
            dv  = ($urandom_range(99) < 55);
            cv  = ($urandom_range(99) < 60);
            cr  = ($urandom_range(99) < 70);
            cidx = $urandom_range(DEPTH - 1);
            if (m_q.size() > 0 && $urandom_range(99) < 75)
                cidx = m_q[$urandom_range(m_q.size() - 1)].idx;
            step(rst, dv, 7'($urandom), 5'($urandom), cv, cidx, $urandom, cr, fl);
        end
        idle(1);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule

// File: doc/rob_commit_buffer.md
Name: rob_commit_buffer

Overview:
- Reorder buffer for the out-of-order RV32I core: circular queue of entries holding {operation[6:0], rd[4:0], value[31:0]} plus a ready bit.
- Dispatch allocates entries at the tail, in program order.
- CDB writeback fills in result values by ROB index.
- Commit retires completed entries in order from the head toward the architectural register file.

Parameters:
- DEPTH, 8, number of entries; power of 2, minimum 2.
- IDX_W, $clog2(DEPTH), width of a ROB index.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- dispatch_valid  in  1  dispatch requests allocation.
- dispatch_ready  out  1  an entry is free.
- dispatch_op  in  7  opcode, rv32i_op_b_t encoding.
- dispatch_rd  in  5  destination register.
- dispatch_rob_idx  out  IDX_W  tail index; valid when dispatch_ready is 1.
- cdb_valid  in  1  result broadcast.
- cdb_rob_idx  in  IDX_W  target entry.
- cdb_value  in  32  result value.
- commit_valid  out  1  head entry is allocated and ready.
- commit_ready  in  1  consumer accepts the head entry.
- commit_op  out  7  head operation.
- commit_rd  out  5  head destination register.
- commit_value  out  32  head value.
- commit_rob_idx  out  IDX_W  head index.
- flush  in  1  discard all entries.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.

Behaviour:
- **Storage and pointers**
  - Per-entry storage: valid, ready, op, rd, value.
  - head and tail are IDX_W+1 bits; the MSB is the wrap bit.
  - empty when head == tail.
  - full when the index bits are equal and the wrap bits differ.
  - Pointers wrap modulo 2*DEPTH.
- **Reset** (rst_n == 0 at clk edge): all valid and ready bits cleared, head = tail = 0. Resulting outputs:
  - dispatch_ready = 1, dispatch_rob_idx = 0.
  - commit_valid = 0, commit_op/rd/value/rob_idx = 0.
  - empty = 1, full = 0.
  - Reset mid-operation discards everything, same as flush.
- **Dispatch**
  - dispatch_ready = !full. It is purely a function of registered state; there is no same-cycle reuse of a slot freed by commit.
  - On dispatch_valid && dispatch_ready:
    - entry[tail] gets valid = 1, ready = 0, op, rd.
    - tail increments.
    - dispatch_rob_idx equals the pre-increment tail.
  - dispatch_valid while full: ignored, no state change.
- **CDB**
  - On cdb_valid with entry[cdb_rob_idx] valid and not ready: value latched, ready set.
  - The entry becomes visible to commit one cycle later.
  - CDB to an unallocated entry or an already-ready entry: ignored.
  - A CDB to an entry allocated in the same cycle is ignored; dispatch wins.
- **Commit**
  - Combinational outputs:
    - commit_valid = entry[head].valid && entry[head].ready && !flush.
    - commit_* fields driven from entry[head]; all zeros when commit_valid = 0.
  - On commit_valid && commit_ready: entry[head].valid and ready cleared, head increments.
  - One retire per cycle maximum.
- **Simultaneity**
  - Dispatch and commit in the same cycle: both take effect and count is unchanged.
  - Dispatch into a full ROB with a commit in the same cycle: dispatch rejected; the slot becomes available next cycle.
- **Flush**
  - Synchronous; highest priority over dispatch, CDB and commit in the same cycle.
  - Next cycle: all entries invalid, head = tail = 0.
  - commit_valid is forced low during the flush cycle.
- **Latency**
  - Dispatch to commit-eligible: at least 2 cycles (dispatch edge, then CDB edge).
  - CDB edge to commit_valid: 1 cycle.

Optional Feature:
- Macro: ROB_CDB_BYPASS_EN.
- **Defined:** a CDB write targeting the head entry makes commit_valid high in the same cycle.
  - commit_value is taken from cdb_value.
  - If commit_ready is also high, the entry retires at that edge.
- **Undefined:** no bypass; the 1-cycle CDB-to-commit latency above applies.

Test Plan:
- Reset then idle → dispatch_ready = 1, commit_valid = 0, empty = 1, full = 0, dispatch_rob_idx = 0.
- Dispatch op 0x33/rd 5, then CDB idx 0 value 0xDEADBEEF, commit_ready held 1:
  - commit_valid = 1 one cycle after the CDB, with commit_rd = 5, commit_value = 0xDEADBEEF, commit_rob_idx = 0.
  - empty = 1 on the following cycle.
- Dispatch 8 entries with DEPTH = 8 → full = 1, dispatch_ready = 0; a 9th dispatch_valid is ignored and tail is unchanged.
- Out-of-order completion: dispatch A (idx 0) and B (idx 1); CDB B = 0x2, then A = 0x1:
  - no commit until A is ready;
  - commits occur in order A (0x1), then B (0x2) on consecutive cycles.
- Wrap-around: over 20 dispatch/complete/commit cycles at DEPTH = 8, indices follow 0..7, 0..7, 0..3, in order, with no loss.
- Flush with 3 entries (one ready) and a simultaneous dispatch_valid and cdb_valid → commit_valid = 0 that cycle; next cycle empty = 1 and dispatch_rob_idx = 0.
  - With ROB_CDB_BYPASS_EN: CDB to the head with commit_ready = 1 → commit in the same cycle with commit_value = cdb_value.
